// File: rtl/parity_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_serial_tx_pkg
// Description : Shared definitions for the parity serial link. These are the
//               frame state encodings, the data bit count and the parity mode
//               constants. The link receiver/checker uses the same values.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_serial_tx_pkg;

  // Frame states, 3-bit encoding shared with the receiver/checker
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Data bits carried per frame
  localparam int unsigned FRAME_DATA_BITS = 8;

  // Parity mode selectors
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Turn the raw XOR of the data into the transmitted parity bit
  function automatic logic parity_bit(input logic raw, input logic mode);
    return raw ^ mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_serial_tx_xor8_1.sv
`default_nettype none
// ============================================================================
// Module      : xor8_1
// Description : 8-input XOR reduction tree with a 1-bit result. It gives the
//               raw (even-sense) parity of a byte.
// Ports       : din    in  8  byte to reduce
//               parity out 1  XOR of all eight bits
// Revision    : 1.0 - initial release
// ============================================================================
module xor8_1 (
  input  logic [7:0] din,
  output logic       parity
);

  logic [3:0] lvl1;
  logic [1:0] lvl2;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lvl1
      assign lvl1[i] = din[2*i] ^ din[2*i+1];
    end
    for (i = 0; i < 2; i++) begin : g_lvl2
      assign lvl2[i] = lvl1[2*i] ^ lvl1[2*i+1];
    end
  endgenerate

  assign parity = lvl2[0] ^ lvl2[1];

endmodule
`default_nettype wire

// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : parity_serial_tx
// Description : Serial byte transmitter. It accepts a byte over valid/ready
//               and sends it on one wire as start, 8 data bits (LSB first),
//               parity and stop bit(s). Each line bit lasts BIT_CYCLES clocks.
// Ports       : clk        in   1  rising-edge clock
//               rst        in   1  synchronous reset, active-high
//               in_data    in   8  word to transmit, sampled on accept
//               in_valid   in   1  producer has a word
//               in_ready   out  1  accept = in_valid & in_ready
//               tx_out     out  1  serial line, idles high
//               tx_busy    out  1  high while a frame is on the line
//               frame_done out  1  pulse in the last cycle of the final stop
// Revision    : 1.0 - initial release
// ============================================================================
module parity_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int STOP_BITS  = 1,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  import parity_serial_tx_pkg::*;

  localparam int   TIMER_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic PAR_MODE = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  tx_state_t           state;
  tx_state_t           state_next;
  logic [TIMER_W-1:0]  bit_timer;
  logic [2:0]          bit_idx;
  logic                stop_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic                par_reg;
  logic                raw_parity;

  logic                bit_last;
  logic                stop_last;
  logic                frame_end;
  logic                accept;

  xor8_1 u_xor8_1 (
    .din    (in_data[7:0]),
    .parity (raw_parity)
  );

  assign bit_last  = (bit_timer == TIMER_W'(BIT_CYCLES - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  // Last clock of the final stop bit: the frame ends here
  assign frame_end = (state == ST_STOP) && bit_last && stop_last;
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  if (bit_last) state_next = ST_DATA;
      ST_DATA:   if (bit_last && (bit_idx == 3'(FRAME_DATA_BITS - 1))) state_next = ST_PARITY;
      ST_PARITY: if (bit_last) state_next = ST_STOP;
      ST_STOP:   if (bit_last && stop_last) state_next = accept ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state == ST_IDLE) || frame_end;
    tx_busy    = (state != ST_IDLE);
    frame_done = frame_end;
    case (state)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = shift_reg[0];
      ST_PARITY: tx_out = par_reg;
      default:   tx_out = 1'b1;
    endcase
  end

  // Bit timer, bit index, stop counter, shift register and parity latch.
  // Any accept restarts the counters, including the back-to-back accept
  // taken in the last stop cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_timer <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
    end else if (accept) begin
      bit_timer <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= in_data;
      par_reg   <= parity_bit(raw_parity, PAR_MODE);
    end else if (state != ST_IDLE) begin
      bit_timer <= bit_last ? '0 : bit_timer + TIMER_W'(1);
      if (bit_last) begin
        if (state == ST_DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 3'd1;
        end
        if (state == ST_STOP) begin
          stop_cnt <= stop_last ? 1'b0 : 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_serial_tx
// Description : Self-checking bench for parity_serial_tx. Two instances are
//               driven by the same inputs. dut_a is even parity, 1 stop bit,
//               4 clk/bit. dut_b is odd parity, 2 stop bits, 1 clk/bit.
//               A frame-position reference model predicts every output of
//               both instances on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_serial_tx;

  localparam int BC_A = 4;
  localparam int SB_A = 1;
  localparam int FL_A = (10 + SB_A) * BC_A;
  localparam int BC_B = 1;
  localparam int SB_B = 2;
  localparam int FL_B = (10 + SB_B) * BC_B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic in_ready_a, tx_out_a, tx_busy_a, frame_done_a;
  logic in_ready_b, tx_out_b, tx_busy_b, frame_done_b;

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(8), .ODD_PARITY(0), .STOP_BITS(SB_A), .BIT_CYCLES(BC_A)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .tx_out(tx_out_a), .tx_busy(tx_busy_a), .frame_done(frame_done_a)
  );

  parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1), .STOP_BITS(SB_B), .BIT_CYCLES(BC_B)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .tx_out(tx_out_b), .tx_busy(tx_busy_b), .frame_done(frame_done_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the current frame (-1 = idle)
  int         pos_a = -1, pos_b = -1;
  logic [7:0] word_a = 8'h00, word_b = 8'h00;
  int         acc_cnt_a = 0;
  int         done_cnt_a = 0, done_cnt_b = 0;
  logic [11:0] cap_a = '0, cap_b = '0;   // mid-bit samples of the line

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready(input int pos, input int fl);
    return (pos < 0) || (pos == fl - 1);
  endfunction

  // Line level for a frame laid out as start, d0..d7, parity, stops
  function automatic logic model_tx(input int pos, input logic [7:0] w, input int bc, input logic odd);
    int idx;
    if (pos < 0) return 1'b1;
    idx = pos / bc;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (idx == 9) return (^w) ^ odd;
    return 1'b1;
  endfunction

  function automatic int model_next(input int pos, input int fl, input logic r, input logic v);
    if (r) return -1;
    if (v && model_ready(pos, fl)) return 0;
    if (pos < 0) return -1;
    return (pos + 1 == fl) ? -1 : pos + 1;
  endfunction

  task automatic check_all();
    check("ready_a", in_ready_a,   model_ready(pos_a, FL_A));
    check("busy_a",  tx_busy_a,    pos_a >= 0);
    check("done_a",  frame_done_a, pos_a == FL_A - 1);
    check("tx_a",    tx_out_a,     model_tx(pos_a, word_a, BC_A, 1'b0));
    check("ready_b", in_ready_b,   model_ready(pos_b, FL_B));
    check("busy_b",  tx_busy_b,    pos_b >= 0);
    check("done_b",  frame_done_b, pos_b == FL_B - 1);
    check("tx_b",    tx_out_b,     model_tx(pos_b, word_b, BC_B, 1'b1));
    if (frame_done_a === 1'b1) done_cnt_a++;
    if (frame_done_b === 1'b1) done_cnt_b++;
    if (pos_a >= 0 && (pos_a % BC_A) == BC_A / 2) cap_a[pos_a / BC_A] = tx_out_a;
    if (pos_b >= 0 && (pos_b % BC_B) == BC_B / 2) cap_b[pos_b / BC_B] = tx_out_b;
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    int na, nb;
    rst = r; in_valid = v; in_data = d;
    @(posedge clk);
    na = model_next(pos_a, FL_A, r, v);
    nb = model_next(pos_b, FL_B, r, v);
    if (!r && v && model_ready(pos_a, FL_A)) begin word_a = d; cap_a = '0; acc_cnt_a++; end
    if (!r && v && model_ready(pos_b, FL_B)) begin word_b = d; cap_b = '0; end
    pos_a = na;
    pos_b = nb;
    #1;
    check_all();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pos_a >= 0 || pos_b >= 0) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("idle_reached", (pos_a < 0 && pos_b < 0), 1);
  endtask

  task automatic send_word(input logic [7:0] w);
    wait_idle();
    cycle(1'b1, w, 1'b0);
    wait_idle();
  endtask

  initial begin
    int n;
    int base;

    // Reset and a long idle stretch
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    done_cnt_a = 0; done_cnt_b = 0;
    for (int i = 0; i < 100; i++) cycle(1'b0, 8'($urandom), 1'b0);
    check("idle_no_done_a", done_cnt_a, 0);
    check("idle_no_done_b", done_cnt_b, 0);

    // 0xA5 frame: bit sequence and frame_done latency
    wait_idle();
    cycle(1'b1, 8'hA5, 1'b0);
    n = 1;
    while (frame_done_a !== 1'b1 && n < 100) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("done_latency_a", n, 44);
    wait_idle();
    check("frame_a5", cap_a, 12'b0_1_0_10100101_0);

    // Parity bits
    send_word(8'h07);
    check("par_even_07", cap_a[9], 1);
    send_word(8'h00);
    check("par_odd_00", cap_b[9], 1);
    send_word(8'hFF);
    check("par_odd_ff", cap_b[9], 1);
    check("par_even_ff", cap_a[9], 0);

    // Back-to-back with in_valid held high
    wait_idle();
    base = acc_cnt_a;
    cycle(1'b1, 8'h01, 1'b0);
    n = 1;
    for (int g = 0; g < 300; g++) begin
      cycle((acc_cnt_a - base) < 2, 8'hFF, 1'b0);
      if (tx_busy_a !== 1'b1) break;
      n++;
    end
    check("b2b_busy_run", n, 88);
    check("b2b_accepts", acc_cnt_a - base, 2);
    check("b2b_second_frame", cap_a, 12'b0_1_0_11111111_0);

    // Input noise during a 0x3C frame
    wait_idle();
    cycle(1'b1, 8'h3C, 1'b0);
    for (int g = 0; g < 100 && pos_a >= 0; g++) begin
      if (pos_a == 20) check("ready_midframe", in_ready_a, 0);
      cycle((pos_a < FL_A - 1) ? 1'($urandom) : 1'b0, 8'($urandom), 1'b0);
    end
    check("frame_3c", cap_a, 12'b0_1_0_00111100_0);

    // Reset in cycle 20 of a frame, with a competing accept attempt
    wait_idle();
    cycle(1'b1, 8'($urandom), 1'b0);
    for (int g = 0; g < 100 && pos_a < 19; g++) cycle(1'b0, 8'h00, 1'b0);
    done_cnt_a = 0;
    cycle(1'b1, 8'($urandom), 1'b1);
    check("rst_tx", tx_out_a, 1);
    check("rst_ready", in_ready_a, 1);
    check("rst_busy", tx_busy_a, 0);
    check("rst_no_done", done_cnt_a, 0);
    send_word(8'h5A);
    check("frame_5a", cap_a, 12'b0_1_0_01011010_0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 60) == 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
